// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if: sample/status bundle between a ring counter driver and its monitor.
// master drives en, ring_in, err_clr; slave returns phase_idx, onehot_ok, locked, err, err_sticky, rev_tick, rev_count.
interface ring_phase_monitor_if #(
   parameter int WIDTH = 4,
   parameter int REV_W = 8
);
   logic                     en;
   logic [WIDTH-1:0]         ring_in;
   logic                     err_clr;
   logic [$clog2(WIDTH)-1:0] phase_idx;
   logic                     onehot_ok;
   logic                     locked;
   logic                     err;
   logic                     err_sticky;
   logic                     rev_tick;
   logic [REV_W-1:0]         rev_count;

   modport master (
      output en, ring_in, err_clr,
      input  phase_idx, onehot_ok, locked,
      input  err, err_sticky, rev_tick, rev_count
   );

   modport slave (
      input  en, ring_in, err_clr,
      output phase_idx, onehot_ok, locked,
      output err, err_sticky, rev_tick, rev_count
   );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring rotates right each enabled cycle; reports lock, phase, revolutions, errors.
// Ports: clk, rst (sync, active-high), bus (slave modport: en/ring_in/err_clr in, registered status out).
module ring_phase_monitor #(
   parameter int WIDTH    = 4,
   parameter int REV_W    = 8,
   parameter int LOCK_CNT = 2
) (
   input logic                 clk,
   input logic                 rst,
   ring_phase_monitor_if.slave bus
);
   localparam int PW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      IDLE, ACQUIRE, LOCKED, FAULT
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] prev, prev_n;
   logic [WIDTH-1:0] expected;
   logic [CW-1:0]    good_cnt, good_cnt_n;
   logic [PW-1:0]    phase, phase_n;
   logic [PW-1:0]    hot_idx;
   logic             onehot, good;
   logic             ok, ok_n;
   logic             locked, locked_n;
   logic             err, err_n;
   logic             sticky, sticky_n;
   logic             tick, tick_n;
   logic [REV_W-1:0] revs, revs_n;

   assign onehot   = $onehot(bus.ring_in);
   assign expected = {prev[0], prev[WIDTH-1:1]};
   assign good     = onehot && (bus.ring_in == expected);

   always_comb begin
      hot_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (bus.ring_in[i]) hot_idx = PW'(i);
   end

   always_comb begin
      state_n    = state;
      prev_n     = prev;
      good_cnt_n = good_cnt;
      phase_n    = phase;
      ok_n       = ok;
      err_n      = 1'b0;
      tick_n     = 1'b0;
      revs_n     = revs;
      if (bus.en) begin
         ok_n = onehot;
         if (onehot) begin
            phase_n = hot_idx;
            prev_n  = bus.ring_in;
         end
         unique case (state)
            IDLE: begin
               if (onehot) begin
                  state_n    = ACQUIRE;
                  good_cnt_n = '0;
               end else begin
                  err_n = 1'b1;
               end
            end
            ACQUIRE: begin
               if (good) begin
                  good_cnt_n = good_cnt + CW'(1);
                  if (good_cnt == CW'(LOCK_CNT - 1))
                     state_n = LOCKED;
               end else if (onehot) begin
                  good_cnt_n = '0;
               end else begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end
            LOCKED: begin
               if (good) begin
                  // Hot bit back at the top means a full lap finished.
                  if (bus.ring_in[WIDTH-1]) begin
                     tick_n = 1'b1;
                     revs_n = revs + REV_W'(1);
                  end
               end else begin
                  state_n = FAULT;
                  err_n   = 1'b1;
               end
            end
            FAULT: ;
         endcase
      end
      if (state == FAULT && bus.err_clr) begin
         state_n    = IDLE;
         prev_n     = '0;
         good_cnt_n = '0;
      end
      // A fresh error outranks a clear in the same cycle.
      sticky_n = (sticky & ~bus.err_clr) | err_n;
      locked_n = (state_n == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         prev     <= '0;
         good_cnt <= '0;
         phase    <= '0;
         ok       <= 1'b0;
         locked   <= 1'b0;
         err      <= 1'b0;
         sticky   <= 1'b0;
         tick     <= 1'b0;
         revs     <= '0;
      end else begin
         state    <= state_n;
         prev     <= prev_n;
         good_cnt <= good_cnt_n;
         phase    <= phase_n;
         ok       <= ok_n;
         locked   <= locked_n;
         err      <= err_n;
         sticky   <= sticky_n;
         tick     <= tick_n;
         revs     <= revs_n;
      end
   end

   assign bus.phase_idx  = phase;
   assign bus.onehot_ok  = ok;
   assign bus.locked     = locked;
   assign bus.err        = err;
   assign bus.err_sticky = sticky;
   assign bus.rev_tick   = tick;
   assign bus.rev_count  = revs;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed stimulus for ring_phase_monitor with an index-arithmetic reference model.
// Model compares all outputs every negedge; literal checks pin key points of each scenario.
module tb_ring_phase_monitor;
   localparam int W  = 4;
   localparam int RW = 8;
   localparam int LC = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ring_phase_monitor_if #(.WIDTH(W), .REV_W(RW)) bus ();

   ring_phase_monitor #(
      .WIDTH(W), .REV_W(RW), .LOCK_CNT(LC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference model: hot index must step down by one (mod W) each sample.
   bit   m_valid = 0;
   int   m_ref;
   int   m_streak;
   bit   m_fault;
   int   e_phase, e_revs;
   bit   e_ok, e_locked, e_err, e_sticky, e_tick;

   function automatic int hot(input logic [W-1:0] v);
      hot = 0;
      for (int i = 0; i < W; i++)
         if (v[i]) hot = i;
   endfunction

   always @(posedge clk) begin
      bit oh, gd, was_fault;
      int idx;
      if (rst) begin
         m_valid = 1; m_ref = -1; m_streak = 0; m_fault = 0;
         e_phase = 0; e_revs = 0; e_ok = 0; e_locked = 0;
         e_err = 0; e_sticky = 0; e_tick = 0;
      end else if (m_valid) begin
         e_err = 0;
         e_tick = 0;
         was_fault = m_fault;
         if (bus.en) begin
            oh  = ($countones(bus.ring_in) == 1);
            idx = hot(bus.ring_in);
            gd  = oh && m_ref >= 0 && idx == (m_ref + W - 1) % W;
            e_ok = oh;
            if (oh) e_phase = idx;
            if (m_fault) begin
            end else if (m_ref < 0) begin
               if (oh) begin m_ref = idx; m_streak = 0; end
               else e_err = 1;
            end else if (m_streak >= LC) begin
               if (gd) begin
                  m_ref = idx;
                  if (idx == W - 1) begin
                     e_tick = 1;
                     e_revs = (e_revs + 1) % (1 << RW);
                  end
               end else begin
                  m_fault = 1;
                  e_err = 1;
               end
            end else begin
               if (gd) begin m_streak++; m_ref = idx; end
               else if (oh) begin m_streak = 0; m_ref = idx; end
               else begin m_ref = -1; m_streak = 0; e_err = 1; end
            end
         end
         if (was_fault && bus.err_clr) begin
            m_fault = 0; m_ref = -1; m_streak = 0;
         end
         e_sticky = (e_sticky && !bus.err_clr) || e_err;
         e_locked = !m_fault && m_ref >= 0 && m_streak >= LC;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m.phase_idx", int'(bus.phase_idx), e_phase);
         chk("m.onehot_ok", int'(bus.onehot_ok), int'(e_ok));
         chk("m.locked", int'(bus.locked), int'(e_locked));
         chk("m.err", int'(bus.err), int'(e_err));
         chk("m.err_sticky", int'(bus.err_sticky), int'(e_sticky));
         chk("m.rev_tick", int'(bus.rev_tick), int'(e_tick));
         chk("m.rev_count", int'(bus.rev_count), e_revs);
      end
   end

   task automatic step(input logic r, input logic e,
                       input logic [W-1:0] ring, input logic c);
      @(negedge clk);
      rst = r; bus.en = e; bus.ring_in = ring; bus.err_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic rev();
      step(0, 1, 4'b0100, 0);
      step(0, 1, 4'b0010, 0);
      step(0, 1, 4'b0001, 0);
      step(0, 1, 4'b1000, 0);
   endtask

   initial begin
      rst = 1; bus.en = 0; bus.ring_in = '0; bus.err_clr = 0;
      // Lock-in
      step(1, 0, 4'b0000, 0);
      step(1, 0, 4'b0000, 0);
      chk("rst.locked", int'(bus.locked), 0);
      chk("rst.rev_count", int'(bus.rev_count), 0);
      step(0, 1, 4'b1000, 0);
      chk("lock.phase3", int'(bus.phase_idx), 3);
      chk("lock.ok", int'(bus.onehot_ok), 1);
      step(0, 1, 4'b0100, 0);
      chk("lock.phase2", int'(bus.phase_idx), 2);
      chk("lock.early", int'(bus.locked), 0);
      step(0, 1, 4'b0010, 0);
      chk("lock.phase1", int'(bus.phase_idx), 1);
      chk("lock.locked", int'(bus.locked), 1);
      chk("lock.err", int'(bus.err), 0);
      // Revolution count and wrap
      step(0, 1, 4'b0001, 0);
      chk("rev.notick", int'(bus.rev_tick), 0);
      step(0, 1, 4'b1000, 0);
      chk("rev.tick", int'(bus.rev_tick), 1);
      chk("rev.count1", int'(bus.rev_count), 1);
      rev();
      chk("rev.count2", int'(bus.rev_count), 2);
      for (int i = 0; i < 254; i++) rev();
      chk("rev.wrap", int'(bus.rev_count), 0);
      // Non-one-hot fault, clear and relock
      step(0, 1, 4'b0110, 0);
      chk("nh.err", int'(bus.err), 1);
      chk("nh.sticky", int'(bus.err_sticky), 1);
      chk("nh.locked", int'(bus.locked), 0);
      chk("nh.ok", int'(bus.onehot_ok), 0);
      chk("nh.phase", int'(bus.phase_idx), 3);
      step(0, 1, 4'b0100, 0);
      chk("nh.nopulse", int'(bus.err), 0);
      step(0, 1, 4'b0010, 0);
      chk("nh.norelock", int'(bus.locked), 0);
      step(0, 0, 4'b0000, 1);
      chk("nh.clr", int'(bus.err_sticky), 0);
      step(0, 1, 4'b0100, 0);
      step(0, 1, 4'b0010, 0);
      step(0, 1, 4'b0001, 0);
      chk("nh.relock", int'(bus.locked), 1);
      chk("nh.revkeep", int'(bus.rev_count), 0);
      // Skip fault, then error beats clear
      step(0, 1, 4'b1000, 0);
      chk("sk.count", int'(bus.rev_count), 1);
      step(0, 1, 4'b0010, 0);
      chk("sk.err", int'(bus.err), 1);
      chk("sk.locked", int'(bus.locked), 0);
      step(0, 1, 4'b0000, 1);
      chk("sk.clr", int'(bus.err_sticky), 0);
      chk("sk.faultquiet", int'(bus.err), 0);
      step(0, 1, 4'b0000, 1);
      chk("sk.errwins.err", int'(bus.err), 1);
      chk("sk.errwins.sticky", int'(bus.err_sticky), 1);
      // Enable gating
      step(0, 1, 4'b1000, 1);
      step(0, 1, 4'b0100, 0);
      step(0, 1, 4'b0010, 0);
      chk("en.locked", int'(bus.locked), 1);
      step(0, 0, 4'b0000, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 4'b1111, 0);
      chk("en.hold.locked", int'(bus.locked), 1);
      chk("en.hold.err", int'(bus.err), 0);
      chk("en.hold.phase", int'(bus.phase_idx), 1);
      step(0, 1, 4'b0001, 0);
      chk("en.resume.err", int'(bus.err), 0);
      step(0, 1, 4'b1000, 0);
      chk("en.resume.count", int'(bus.rev_count), 2);
      for (int i = 0; i < 3; i++) rev();
      chk("rm.count5", int'(bus.rev_count), 5);
      // Reset mid-operation
      step(1, 1, 4'b0100, 1);
      chk("rm.locked", int'(bus.locked), 0);
      chk("rm.count", int'(bus.rev_count), 0);
      chk("rm.ok", int'(bus.onehot_ok), 0);
      chk("rm.phase", int'(bus.phase_idx), 0);
      chk("rm.sticky", int'(bus.err_sticky), 0);
      step(0, 1, 4'b0100, 0);
      chk("rm.acq.ok", int'(bus.onehot_ok), 1);
      chk("rm.acq.locked", int'(bus.locked), 0);
      step(0, 0, 4'b0000, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Downstream consumer of the 4-bit one-hot ring counter. Samples the ring output each enabled cycle and checks that it is one-hot.
- Checks that each sample is the right-rotate of the previous one, following the sequence 1000->0100->0010->0001->1000.
- Reports lock status, the binary phase index and the completed-revolution count, and raises pulse and sticky error flags.
- Sits between the ring counter and the control logic that gates on ring health.

Parameters:
- WIDTH, 4, ring width in bits (≥2).
- REV_W, 8, width of the revolution counter.
- LOCK_CNT, 2, consecutive correct transitions required to declare lock (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  sample enable; the ring advances once per cycle while en=1.
- ring_in  input  WIDTH  ring counter output.
- err_clr  input  1  clears err_sticky and releases FAULT.
- phase_idx  output  $clog2(WIDTH)  index of the hot bit (bit WIDTH-1 -> WIDTH-1).
- onehot_ok  output  1  the last enabled sample was one-hot.
- locked  output  1  high in LOCKED state.
- err  output  1  one-cycle pulse on a detected fault.
- err_sticky  output  1  latched fault flag.
- rev_tick  output  1  one-cycle pulse per completed revolution.
- rev_count  output  REV_W  completed revolutions, modulo 2^REV_W.

Behaviour:
- All outputs are registered. A sample at edge N is reflected after edge N, giving 1-cycle latency.
- Reset (rst=1 at an edge): state=IDLE, prev=0, good_cnt=0, and every output = 0. Reset has priority over every other input.
- onehot = exactly one bit of ring_in is set. expected = {prev[0], prev[WIDTH-1:1]}. good = onehot && ring_in==expected.
- en=0: no state, counter or output change, except err_clr handling and err/rev_tick dropping to 0. ring_in is ignored.
- On an en=1 sample:
  - onehot_ok <= onehot.
  - phase_idx updates only if onehot; otherwise it holds.
  - prev <= ring_in if onehot.
- IDLE:
  - onehot -> ACQUIRE, good_cnt=0.
  - Not onehot -> stay in IDLE, err pulse, err_sticky=1.
- ACQUIRE:
  - good -> good_cnt+1. When good_cnt reaches LOCK_CNT, go to LOCKED, locked=1.
  - onehot but wrong rotation -> good_cnt=0, stay in ACQUIRE, no error.
  - Not onehot -> IDLE, err pulse, err_sticky=1.
- LOCKED:
  - good -> stay in LOCKED.
  - If the sample is good and has bit WIDTH-1 hot (wrap from bit 0): rev_tick pulses and rev_count increments, wrapping from 2^REV_W-1 to 0.
  - Any non-good sample -> FAULT, locked=0, err pulse, err_sticky=1.
- FAULT:
  - Samples update onehot_ok and phase_idx only; no new err pulses are generated.
  - err_clr=1 -> IDLE (prev=0, good_cnt=0).
- err_clr:
  - In any state, clears err_sticky.
  - If a new error is detected in the same cycle, the error wins: err pulses and err_sticky stays 1.
- rev_count counts only in LOCKED and is cleared only by rst. It is retained through FAULT and relock.
- Lock latency: from the first one-hot sample, locked rises after LOCK_CNT further good samples.

Test Plan:
- (WIDTH=4, LOCK_CNT=2, REV_W=8 for all scenarios.)
- Lock-in: rst=1 for 2 cycles, then en=1 with ring_in 1000, 0100, 0010 -> phase_idx 3, 2, 1; onehot_ok=1; locked=1 after the 0010 edge; err stays 0.
- Revolution count: continue with 0001, 1000 -> rev_tick pulses for exactly 1 cycle after the 1000 edge and rev_count=1. Run 256 revolutions -> rev_count wraps to 0.
- Non-one-hot fault: while locked, drive 0110 -> err pulses 1 cycle, err_sticky=1, locked=0, onehot_ok=0, phase_idx holds. Drive valid data -> no relock. Pulse err_clr, then 0100, 0010, 0001 -> locked=1 again; rev_count is retained.
- Skip fault: while locked, drive 1000 then 0010 -> err pulse, FAULT. Assert err_clr in the same cycle as a new IDLE error (0000) -> err_sticky stays 1.
- Enable gating: while locked, set en=0 and drive 0000 and 1111 for 5 cycles -> no err, locked stays 1, all outputs hold. Resume with the correct next phase -> no error.
- Reset mid-operation: assert rst while LOCKED with rev_count=5 -> after the next edge all outputs are 0 and state is IDLE, even with err_clr=1 and en=1 in the same cycle.
